// File: rtl/run_sum_acc_if.sv
// rtl/run_sum_acc_if.sv - sample stream and run report bundle for run_sum_acc
interface run_sum_acc_if #(
  parameter int DW = 8,
  parameter int SW = 16,
  parameter int CW = 8
);
  logic          val;
  logic [DW-1:0] data;
  logic          dir;
  logic          strict;
  logic          clr;
  logic [SW-1:0] sum;
  logic [CW-1:0] run_len;
  logic          sat;
  logic          run_end;
  logic [SW-1:0] end_sum;
  logic [CW-1:0] end_len;
  logic [SW-1:0] best_sum;
  logic [CW-1:0] best_len;

  modport master (
    output val, data, dir, strict, clr,
    input  sum, run_len, sat, run_end, end_sum, end_len, best_sum, best_len
  );

  modport slave (
    input  val, data, dir, strict, clr,
    output sum, run_len, sat, run_end, end_sum, end_len, best_sum, best_len
  );
endinterface

// File: rtl/run_sum_acc.sv
// rtl/run_sum_acc.sv - monotonic-run accumulator with saturating sums and best-run tracking
module run_sum_acc #(
  parameter int DW = 8,
  parameter int SW = 16,
  parameter int CW = 8
) (
  input logic         clk,
  input logic         rst_b,
  run_sum_acc_if.slave bus
);
  localparam logic [SW-1:0] SUM_MAX = {SW{1'b1}};
  localparam logic [CW-1:0] LEN_MAX = {CW{1'b1}};

  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] run_len_q, run_len_d;
  logic          sat_q, sat_d;
  logic          run_end_q, run_end_d;
  logic [SW-1:0] end_sum_q, end_sum_d;
  logic [CW-1:0] end_len_q, end_len_d;
  logic [SW-1:0] best_sum_q, best_sum_d;
  logic [CW-1:0] best_len_q, best_len_d;
  logic [DW-1:0] last_q, last_d;
  logic          have_last_q, have_last_d;

  logic          cont;
  logic [SW:0]   sum_ext;
  logic [CW:0]   len_ext;

  always_comb begin
    if (bus.dir == 1'b0) begin
      cont = bus.strict ? (bus.data > last_q) : (bus.data >= last_q);
    end else begin
      cont = bus.strict ? (bus.data < last_q) : (bus.data <= last_q);
    end
  end

  // One extra bit on both adders exposes the carry used for clamping.
  always_comb begin
    sum_ext = {1'b0, sum_q} + {1'b0, SW'(bus.data)};
    len_ext = {1'b0, run_len_q} + {{CW{1'b0}}, 1'b1};
  end

  always_comb begin
    sum_d       = sum_q;
    run_len_d   = run_len_q;
    sat_d       = sat_q;
    run_end_d   = 1'b0;
    end_sum_d   = end_sum_q;
    end_len_d   = end_len_q;
    best_sum_d  = best_sum_q;
    best_len_d  = best_len_q;
    last_d      = last_q;
    have_last_d = have_last_q;

    if (bus.clr) begin
      sum_d       = '0;
      run_len_d   = '0;
      sat_d       = 1'b0;
      have_last_d = 1'b0;
    end else if (bus.val) begin
      last_d      = bus.data;
      have_last_d = 1'b1;
      if (!have_last_q) begin
        sum_d     = SW'(bus.data);
        run_len_d = CW'(1);
        sat_d     = 1'b0;
      end else if (cont) begin
        if (sum_ext[SW]) begin
          sum_d = SUM_MAX;
          sat_d = 1'b1;
        end else begin
          sum_d = sum_ext[SW-1:0];
        end
        if (len_ext[CW]) begin
          run_len_d = LEN_MAX;
          sat_d     = 1'b1;
        end else begin
          run_len_d = len_ext[CW-1:0];
        end
      end else begin
        run_end_d = 1'b1;
        end_sum_d = sum_q;
        end_len_d = run_len_q;
        // Strictly greater only: a tie keeps the earlier run as best.
        if (sum_q > best_sum_q) begin
          best_sum_d = sum_q;
          best_len_d = run_len_q;
        end
        sum_d     = SW'(bus.data);
        run_len_d = CW'(1);
        sat_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sum_q       <= '0;
      run_len_q   <= '0;
      sat_q       <= 1'b0;
      run_end_q   <= 1'b0;
      end_sum_q   <= '0;
      end_len_q   <= '0;
      best_sum_q  <= '0;
      best_len_q  <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      run_len_q   <= run_len_d;
      sat_q       <= sat_d;
      run_end_q   <= run_end_d;
      end_sum_q   <= end_sum_d;
      end_len_q   <= end_len_d;
      best_sum_q  <= best_sum_d;
      best_len_q  <= best_len_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.run_len  = run_len_q;
  assign bus.sat      = sat_q;
  assign bus.run_end  = run_end_q;
  assign bus.end_sum  = end_sum_q;
  assign bus.end_len  = end_len_q;
  assign bus.best_sum = best_sum_q;
  assign bus.best_len = best_len_q;
endmodule

// File: tb/tb_run_sum_acc.sv
// tb/tb_run_sum_acc.sv - scoreboard bench for run_sum_acc (default and SW=8 instances)
module tb_run_sum_acc;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  run_sum_acc_if #(.DW(8), .SW(16), .CW(8)) bus0 ();
  run_sum_acc_if #(.DW(8), .SW(8),  .CW(8)) bus1 ();

  run_sum_acc #(.DW(8), .SW(16), .CW(8)) u0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
  run_sum_acc #(.DW(8), .SW(8),  .CW(8)) u1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

  typedef struct {
    bit    sel;
    string tag;
    int    sum, len, sat, run_end, esum, elen, bsum, blen;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every edge the DUT presents a fresh registered result.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        chk({e.tag, " sum"},      int'(bus0.sum),      e.sum);
        chk({e.tag, " run_len"},  int'(bus0.run_len),  e.len);
        chk({e.tag, " sat"},      int'(bus0.sat),      e.sat);
        chk({e.tag, " run_end"},  int'(bus0.run_end),  e.run_end);
        chk({e.tag, " end_sum"},  int'(bus0.end_sum),  e.esum);
        chk({e.tag, " end_len"},  int'(bus0.end_len),  e.elen);
        chk({e.tag, " best_sum"}, int'(bus0.best_sum), e.bsum);
        chk({e.tag, " best_len"}, int'(bus0.best_len), e.blen);
      end else begin
        chk({e.tag, " sum"},      int'(bus1.sum),      e.sum);
        chk({e.tag, " run_len"},  int'(bus1.run_len),  e.len);
        chk({e.tag, " sat"},      int'(bus1.sat),      e.sat);
        chk({e.tag, " run_end"},  int'(bus1.run_end),  e.run_end);
        chk({e.tag, " end_sum"},  int'(bus1.end_sum),  e.esum);
        chk({e.tag, " end_len"},  int'(bus1.end_len),  e.elen);
        chk({e.tag, " best_sum"}, int'(bus1.best_sum), e.bsum);
        chk({e.tag, " best_len"}, int'(bus1.best_len), e.blen);
      end
    end
  end

  // One clock of stimulus plus the hand-computed state expected after the edge.
  task automatic step(input bit sel, input bit rb, input bit v, input int d, input bit dr,
                      input bit st, input bit c, input int es, input int el, input int esat,
                      input int eend, input int ees, input int eel, input int ebs, input int ebl,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst_b = rb;
    bus0.val = 1'b0; bus0.clr = 1'b0; bus0.data = '0; bus0.dir = 1'b0; bus0.strict = 1'b0;
    bus1.val = 1'b0; bus1.clr = 1'b0; bus1.data = '0; bus1.dir = 1'b0; bus1.strict = 1'b0;
    if (!sel) begin
      bus0.val = v; bus0.data = 8'(d); bus0.dir = dr; bus0.strict = st; bus0.clr = c;
    end else begin
      bus1.val = v; bus1.data = 8'(d); bus1.dir = dr; bus1.strict = st; bus1.clr = c;
    end
    e.sel = sel; e.tag = tag;
    e.sum = es; e.len = el; e.sat = esat; e.run_end = eend;
    e.esum = ees; e.elen = eel; e.bsum = ebs; e.blen = ebl;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    bus0.val = 1'b0; bus0.clr = 1'b0; bus0.data = '0; bus0.dir = 1'b0; bus0.strict = 1'b0;
    bus1.val = 1'b0; bus1.clr = 1'b0; bus1.data = '0; bus1.dir = 1'b0; bus1.strict = 1'b0;

    //    sel rb v  d   dr st c   sum len sat end esum elen bsum blen
    step(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0, "rst0");
    step(0, 0, 1, 9,  0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0, "rst1");
    step(0, 1, 1, 5,  0, 0, 0,  5,  1, 0, 0,  0, 0,  0, 0, "first5");

    step(0, 1, 0, 0,  0, 0, 1,  0,  0, 0, 0,  0, 0,  0, 0, "clrA");
    step(0, 1, 1, 3,  0, 0, 0,  3,  1, 0, 0,  0, 0,  0, 0, "inc3");
    step(0, 1, 1, 3,  0, 0, 0,  6,  2, 0, 0,  0, 0,  0, 0, "inc3b");
    step(0, 1, 1, 7,  0, 0, 0, 13,  3, 0, 0,  0, 0,  0, 0, "inc7");
    step(0, 1, 1, 2,  0, 0, 0,  2,  1, 0, 1, 13, 3, 13, 3, "inc_brk");

    step(0, 1, 0, 0,  0, 0, 1,  0,  0, 0, 0, 13, 3, 13, 3, "clrB");
    step(0, 1, 1, 9,  1, 1, 0,  9,  1, 0, 0, 13, 3, 13, 3, "dec9");
    step(0, 1, 1, 4,  1, 1, 0, 13,  2, 0, 0, 13, 3, 13, 3, "dec4");
    step(0, 1, 1, 4,  1, 1, 0,  4,  1, 0, 1, 13, 2, 13, 3, "dec_eq_brk");

    step(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0, "rst2");
    step(0, 1, 1, 10, 0, 0, 0, 10,  1, 0, 0,  0, 0,  0, 0, "b10");
    step(0, 1, 1, 5,  0, 0, 0,  5,  1, 0, 1, 10, 1, 10, 1, "b_brk10");
    step(0, 1, 0, 77, 0, 0, 0,  5,  1, 0, 0, 10, 1, 10, 1, "gap");
    step(0, 1, 1, 25, 0, 0, 0, 30,  2, 0, 0, 10, 1, 10, 1, "b25");
    step(0, 1, 1, 1,  0, 0, 0,  1,  1, 0, 1, 30, 2, 30, 2, "b_brk30");
    step(0, 1, 1, 9,  0, 0, 0, 10,  2, 0, 0, 30, 2, 30, 2, "b9");
    step(0, 1, 1, 20, 0, 0, 0, 30,  3, 0, 0, 30, 2, 30, 2, "b20");
    step(0, 1, 1, 0,  0, 0, 0,  0,  1, 0, 1, 30, 3, 30, 2, "b_tie30");

    step(0, 1, 0, 0,  0, 0, 1,  0,  0, 0, 0, 30, 3, 30, 2, "clrC");
    step(0, 1, 1, 4,  0, 0, 0,  4,  1, 0, 0, 30, 3, 30, 2, "c4");
    step(0, 1, 1, 6,  0, 0, 0, 10,  2, 0, 0, 30, 3, 30, 2, "c6");
    step(0, 1, 1, 1,  0, 0, 1,  0,  0, 0, 0, 30, 3, 30, 2, "clr_val");
    step(0, 1, 1, 1,  0, 0, 0,  1,  1, 0, 0, 30, 3, 30, 2, "after_clr");

    step(1, 1, 1, 200, 0, 0, 0, 200, 1, 0, 0,   0, 0,   0, 0, "s200");
    step(1, 1, 1, 200, 0, 0, 0, 255, 2, 1, 0,   0, 0,   0, 0, "s_clamp");
    step(1, 1, 1, 201, 0, 0, 0, 255, 3, 1, 0,   0, 0,   0, 0, "s_hold");
    step(1, 1, 1, 0,   0, 0, 0,   0, 1, 0, 1, 255, 3, 255, 3, "s_brk");

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
